// File: rtl/dram_arbiter_pkg.sv
// dram_arbiter_pkg: shared FSM state type and default sizing for the DRAM arbiter.
// The read-latency counter width covers the largest supported RD_LAT.
package dram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_RD_LAT    = 1;
    localparam int LAT_CNT_W     = 3;

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// rr_pick: rotating-priority selector, first set request at or above base (with wrap).
// Returns the winner both one-hot and as an index.
module rr_pick
    import dram_arbiter_pkg::*;
#(
    parameter int N  = DEF_NUM_CORES,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    localparam int SW = IW + 1;

    logic [SW-1:0] s;
    logic [IW-1:0] j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        s     = '0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            s = {1'b0, base} + SW'(i);
            if (s >= SW'(N)) s = s - SW'(N);
            j = s[IW-1:0];
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter sharing one DRAM port among NUM_CORES cores.
// Define DRAM_ARBITER_LOCK_EN to add core_lock for back-to-back locked accesses.
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_LAT    = DEF_RD_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
`ifdef DRAM_ARBITER_LOCK_EN
    input  logic [NUM_CORES-1:0]        core_lock,
`endif
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_done,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [ADDR_W-1:0]           dram_addr,
    output logic                        dram_we,
    output logic [DATA_W-1:0]           dram_wdata,
    input  logic [DATA_W-1:0]           dram_rdata,
    output logic                        busy
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    state_t               state_q, state_d;
    logic [IW-1:0]        last_q, base, pick_idx;
    logic [NUM_CORES-1:0] gnt_q, req_eff, pick_gnt;
    logic                 pick_valid;
    logic                 we_q, we_sel;
    logic [ADDR_W-1:0]    addr_q, addr_sel;
    logic [DATA_W-1:0]    wdata_q, wdata_sel, rdata_q;
    logic [LAT_CNT_W-1:0] cnt_q;

    assign base = (last_q == IW'(NUM_CORES - 1)) ? '0 : last_q + IW'(1);

`ifdef DRAM_ARBITER_LOCK_EN
    logic lock_q;
    logic lock_hold;

    // gnt_q still names the previous winner while idle
    assign lock_hold = lock_q && |(core_req & gnt_q);
    assign req_eff   = lock_hold ? (core_req & gnt_q) : core_req;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_q <= 1'b0;
        end else if (state_q == DONE) begin
            lock_q <= |(core_lock & gnt_q);
        end else if (state_q == IDLE && !lock_hold) begin
            lock_q <= 1'b0;
        end
    end
`else
    assign req_eff = core_req;
`endif

    rr_pick #(
        .N  (NUM_CORES),
        .IW (IW)
    ) u_pick (
        .req   (req_eff),
        .base  (base),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick_gnt[i]) begin
                we_sel    = core_we[i];
                addr_sel  = core_addr[i*ADDR_W +: ADDR_W];
                wdata_sel = core_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        core_gnt   = '0;
        core_done  = '0;
        core_rdata = '0;
        dram_addr  = '0;
        dram_wdata = '0;
        dram_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) state_d = ACCESS;
            end
            ACCESS: begin
                state_d = (RD_LAT > 0) ? WAIT : DONE;
                dram_we = we_q;
            end
            WAIT: begin
                if (cnt_q == LAT_CNT_W'(RD_LAT)) state_d = DONE;
            end
            DONE: begin
                state_d    = IDLE;
                core_done  = gnt_q;
                core_rdata = rdata_q;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE) begin
            busy       = 1'b1;
            core_gnt   = gnt_q;
            dram_addr  = addr_q;
            dram_wdata = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_CORES - 1);
            gnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_valid) begin
                last_q  <= pick_idx;
                gnt_q   <= pick_gnt;
                we_q    <= we_sel;
                addr_q  <= addr_sel;
                wdata_q <= wdata_sel;
            end
            if (state_q == ACCESS) begin
                cnt_q <= LAT_CNT_W'(1);
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + LAT_CNT_W'(1);
            end
            // last latency cycle: DRAM data is valid now
            if (state_q != DONE && state_d == DONE) begin
                rdata_q <= we_q ? '0 : dram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter, compared every cycle.
module tb_dram_arbiter;

    localparam int N   = 4;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int LAT = 1;

    logic            clk;
    logic            rst;
    logic [N-1:0]    core_req;
    logic [N-1:0]    core_we;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdata;
    logic [N-1:0]    core_gnt;
    logic [N-1:0]    core_done;
    logic [DW-1:0]   core_rdata;
    logic [AW-1:0]   dram_addr;
    logic            dram_we;
    logic [DW-1:0]   dram_wdata;
    logic [DW-1:0]   dram_rdata;
    logic            busy;
`ifdef DRAM_ARBITER_LOCK_EN
    logic [N-1:0]    core_lock;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    dram_arbiter #(
        .NUM_CORES (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RD_LAT    (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
`ifdef DRAM_ARBITER_LOCK_EN
        .core_lock  (core_lock),
`endif
        .core_gnt   (core_gnt),
        .core_done  (core_done),
        .core_rdata (core_rdata),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: one access is "age" cycles old since its grant edge.
    bit            model_ok = 1'b0;
    bit            m_busy   = 1'b0;
    int            m_age    = 0;
    int            m_cur    = 0;
    int            m_last   = N - 1;
    bit            m_lock   = 1'b0;
    bit            m_we     = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic [DW-1:0] m_rdata  = '0;

    initial begin
        logic [N-1:0] cand;
        int           win;
        int           c;
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_busy   = 1'b0;
                m_age    = 0;
                m_last   = N - 1;
                m_lock   = 1'b0;
                model_ok = 1'b1;
            end else if (m_busy) begin
                if (m_age == LAT + 1) m_rdata = m_we ? '0 : dram_rdata;
                if (m_age == LAT + 2) begin
                    m_busy = 1'b0;
`ifdef DRAM_ARBITER_LOCK_EN
                    m_lock = core_lock[m_cur];
`endif
                end else begin
                    m_age++;
                end
            end else begin
                cand = core_req;
                if (m_lock) begin
                    if (core_req[m_last]) cand = N'(1) << m_last;
                    else m_lock = 1'b0;
                end
                win = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (win < 0 && cand[c]) win = c;
                end
                if (win >= 0) begin
                    m_busy  = 1'b1;
                    m_age   = 1;
                    m_cur   = win;
                    m_last  = win;
                    m_we    = core_we[win];
                    m_addr  = core_addr[win*AW +: AW];
                    m_wdata = core_wdata[win*DW +: DW];
                end
            end
        end
    end

    initial begin
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        forever begin
            @(negedge clk);
            if (model_ok) begin
                eg = m_busy ? (N'(1) << m_cur) : '0;
                ed = (m_busy && m_age == LAT + 2) ? eg : '0;
                check("m_gnt", core_gnt, eg);
                check("m_done", core_done, ed);
                check("m_busy", busy, m_busy);
                check("m_dram_we", dram_we, m_busy && m_age == 1 && m_we);
                check("m_dram_addr", dram_addr, m_busy ? m_addr : '0);
                check("m_dram_wdata", dram_wdata, m_busy ? m_wdata : '0);
                if (ed != '0) check("m_rdata", core_rdata, m_rdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst      = 1'b0;
        core_req = '0;
        core_we  = '0;
`ifdef DRAM_ARBITER_LOCK_EN
        core_lock = '0;
`endif
        step();
        rst = 1'b1;
    endtask

    task automatic t_read();
        do_reset();
        core_we[2]              = 1'b0;
        core_addr[2*AW +: AW]   = 12'h00A;
        dram_rdata              = 32'hDEADBEEF;
        core_req[2]             = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_gnt", core_gnt, 0);
        check("rst_done", core_done, 0);
        check("rst_addr", dram_addr, 0);
        step();
        @(negedge clk);
        check("rd_gnt", core_gnt, 4'b0100);
        check("rd_addr", dram_addr, 12'h00A);
        check("rd_we", dram_we, 0);
        step();
        @(negedge clk);
        check("rd_wait_done", core_done, 0);
        step();
        @(negedge clk);
        check("rd_done", core_done, 4'b0100);
        check("rd_data", core_rdata, 32'hDEADBEEF);
        step();
        core_req[2] = 1'b0;
    endtask

    task automatic t_write();
        do_reset();
        core_we[0]            = 1'b1;
        core_addr[0 +: AW]    = 12'h123;
        core_wdata[0 +: DW]   = 32'h55AA55AA;
        core_req[0]           = 1'b1;
        step();
        @(negedge clk);
        check("wr_we", dram_we, 1);
        check("wr_addr", dram_addr, 12'h123);
        check("wr_wdata", dram_wdata, 32'h55AA55AA);
        check("wr_gnt", core_gnt, 4'b0001);
        step();
        @(negedge clk);
        check("wr_we_low", dram_we, 0);
        check("wr_wait_busy", busy, 1);
        step();
        @(negedge clk);
        check("wr_done", core_done, 4'b0001);
        check("wr_rdata", core_rdata, 0);
        step();
        core_req[0] = 1'b0;
        core_we[0]  = 1'b0;
    endtask

    task automatic t_rr();
        int order[$];
        int when[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int cyc = 0;
        do_reset();
        core_req = '1;
        while (order.size() < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++)
                if (core_done[i]) begin
                    order.push_back(i);
                    when.push_back(cyc);
                end
        end
        check("rr_count", order.size(), 5);
        for (int j = 0; j < order.size() && j < 5; j++) begin
            check("rr_order", order[j], exp_order[j]);
            if (j > 0) check("rr_spacing", when[j] - when[j-1], 4);
        end
        step();
        core_req = '0;
    endtask

    task automatic t_rst_mid();
        do_reset();
        core_we[1]  = 1'b0;
        core_req[1] = 1'b1;
        step();
        step();
        rst         = 1'b0;
        core_req[0] = 1'b1;
        @(negedge clk);
        check("rm_busy_wait", busy, 1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rm_no_done", core_done, 0);
        check("rm_busy", busy, 0);
        check("rm_gnt", core_gnt, 0);
        check("rm_addr", dram_addr, 0);
        check("rm_we", dram_we, 0);
        step();
        @(negedge clk);
        check("rm_core0_wins", core_gnt, 4'b0001);
    endtask

    task automatic t_drop();
        do_reset();
        core_we[3]            = 1'b0;
        core_addr[3*AW +: AW] = 12'h3C3;
        core_req[3]           = 1'b1;
        step();
        core_req[3]           = 1'b0;
        core_addr[3*AW +: AW] = 12'hFFF;
        core_we[3]            = 1'b1;
        @(negedge clk);
        check("dr_addr", dram_addr, 12'h3C3);
        check("dr_we", dram_we, 0);
        step();
        step();
        @(negedge clk);
        check("dr_done", core_done, 4'b1000);
        check("dr_addr_done", dram_addr, 12'h3C3);
    endtask

`ifdef DRAM_ARBITER_LOCK_EN
    task automatic t_lock();
        int order[$];
        int exp_order[4] = '{1, 1, 2, 0};
        int cyc = 0;
        bit n1 = 1'b0;
        logic [N-1:0] d;
        do_reset();
        core_lock[1] = 1'b1;
        core_req[1]  = 1'b1;
        step();
        core_req[0] = 1'b1;
        core_req[2] = 1'b1;
        while (order.size() < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            d = core_done;
            for (int i = 0; i < N; i++)
                if (d[i]) order.push_back(i);
            step();
            if (d[1] && !n1) begin
                core_lock[1] = 1'b0;
                n1 = 1'b1;
            end else if (d[1]) begin
                core_req[1] = 1'b0;
            end
            if (d[0]) core_req[0] = 1'b0;
            if (d[2]) core_req[2] = 1'b0;
        end
        check("lk_count", order.size(), 4);
        for (int j = 0; j < order.size() && j < 4; j++)
            check("lk_order", order[j], exp_order[j]);
    endtask
`endif

    initial begin
        logic [N-1:0] d;
        rst        = 1'b0;
        core_req   = '0;
        core_we    = '0;
        core_addr  = '0;
        core_wdata = '0;
        dram_rdata = '0;
`ifdef DRAM_ARBITER_LOCK_EN
        core_lock  = '0;
`endif
        step();
        step();
        rst = 1'b1;

        t_read();
        t_write();
        t_rr();
        t_rst_mid();
        t_drop();
`ifdef DRAM_ARBITER_LOCK_EN
        t_lock();
`endif

        do_reset();
        repeat (3000) begin
            @(negedge clk);
            d = core_done;
            step();
            rst = ($urandom_range(0, 299) != 0);
            dram_rdata = $urandom;
            for (int i = 0; i < N; i++) begin
                if (d[i]) core_req[i] = 1'b0;
                else if (!core_req[i]) core_req[i] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 31) == 0) core_req[i] = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    core_we[i]               = 1'($urandom_range(0, 1));
                    core_addr[i*AW +: AW]    = AW'($urandom);
                    core_wdata[i*DW +: DW]   = $urandom;
                end
`ifdef DRAM_ARBITER_LOCK_EN
                if ($urandom_range(0, 7) == 0)
                    core_lock[i] = 1'($urandom_range(0, 1));
`endif
            end
        end

        step();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter NUM_CORES, 4, number of requesting cores, range 2..8.
REQ-002 Parameter ADDR_W, 12, DRAM word address width.
REQ-003 Parameter DATA_W, 32, DRAM data width.
REQ-004 Parameter RD_LAT, 1, DRAM read latency in cycles, range 0..7.
REQ-005 Port clk  in  1  single clock; all state changes on rising edge.
REQ-006 Port rst  in  1  synchronous, active-low reset.
REQ-007 Port core_req  in  NUM_CORES  per-core access request, held high until core_done.
REQ-008 Port core_we  in  NUM_CORES  per-core write-enable qualifier, 1 = write.
REQ-009 Port core_addr  in  NUM_CORES*ADDR_W  flattened addresses, core i at bits [i*ADDR_W +: ADDR_W].
REQ-010 Port core_wdata  in  NUM_CORES*DATA_W  flattened write data, same packing.
REQ-011 Port core_gnt  out  NUM_CORES  one-hot grant, high from ACCESS through DONE.
REQ-012 Port core_done  out  NUM_CORES  one-cycle completion pulse to the granted core.
REQ-013 Port core_rdata  out  DATA_W  read data, valid only while core_done is high.
REQ-014 Port dram_addr  out  ADDR_W  DRAM address.
REQ-015 Port dram_we  out  1  DRAM write strobe.
REQ-016 Port dram_wdata  out  DATA_W  DRAM write data.
REQ-017 Port dram_rdata  in  DATA_W  DRAM read data, valid RD_LAT cycles after the address cycle.
REQ-018 Port busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS, WAIT, DONE; IDLE->ACCESS on any core_req, ACCESS->WAIT if RD_LAT>0 else ->DONE, WAIT->DONE after RD_LAT cycles, DONE->IDLE unconditionally.
REQ-020 In IDLE, the winner SHALL be the first requesting core searching upward (with wrap) from last_winner+1; its we/addr/wdata SHALL be latched on the same edge.
REQ-021 last_winner SHALL update to the winner on the IDLE->ACCESS edge.
REQ-022 dram_addr and dram_wdata SHALL hold the latched values from ACCESS through DONE and be 0 in IDLE.
REQ-023 dram_we SHALL be high for exactly the single ACCESS cycle of a write and low otherwise.
REQ-024 For reads, dram_rdata SHALL be captured at the end of the cycle RD_LAT cycles after ACCESS and driven on core_rdata during DONE; for writes, core_rdata SHALL be 0.
REQ-025 A request sampled in IDLE at edge k SHALL produce core_done at cycle k+2+RD_LAT; throughput is one access per RD_LAT+3 cycles.
REQ-026 Deassertion of core_req by the granted core mid-access SHALL NOT abort the access; changes on core_addr/core_we/core_wdata after latching SHALL be ignored.
REQ-027 Simultaneous requests SHALL be served in round-robin order, no core waiting more than NUM_CORES-1 other accesses.
REQ-028 core_gnt and core_done SHALL be zero in IDLE.

Reset
REQ-029 With rst low at a clock edge: state=IDLE, last_winner=NUM_CORES-1 (core 0 wins first), all outputs 0, latches cleared.
REQ-030 Reset asserted mid-access SHALL abandon the access with no core_done pulse and dram_we low from the next cycle.

Configuration
REQ-031 Macro DRAM_ARBITER_LOCK_EN defined: input core_lock NUM_CORES added; if core_lock of the winner is high during DONE, the next arbitration SHALL consider only that core while it keeps core_req high, ending when it completes an access with core_lock low or drops core_req in IDLE.
REQ-032 Macro undefined: core_lock port and lock state SHALL be absent; pure round-robin.

Structure
REQ-033 Package dram_arbiter_pkg SHALL hold the FSM state enum, default widths, and the RD_LAT counter width constant.
REQ-034 Sub-module rr_pick SHALL implement the combinational rotating-priority winner selection (req vector, base index -> one-hot, valid).

Verification
REQ-035 Single read: core 2 req, addr 0x00A, RD_LAT=1, dram_rdata=0xDEADBEEF -> dram_addr=0x00A, core_done[2] at cycle k+3, core_rdata=0xDEADBEEF.
REQ-036 Single write: core 0 req, we=1, addr 0x123, wdata 0x55AA55AA -> dram_we high exactly one cycle with those values, core_rdata=0.
REQ-037 All four cores request continuously after reset -> grant order 0,1,2,3,0, each done spaced 4 cycles.
REQ-038 Reset low during WAIT of core 1 read -> no core_done, all outputs 0 next cycle, core 0 wins after release.
REQ-039 Core 3 drops req and changes addr in ACCESS -> access completes to original address, core_done[3] still pulses.
REQ-040 LOCK_EN: core 1 with core_lock=1 for two accesses while cores 0,2 request -> order 1,1,2,0.
